// File: rtl/iter_muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// The start/busy/done handshake stalls the pipeline; flush squashes an in-flight operation.
module iter_muldiv_unit #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              cmd,
  input  logic [WIDTH-1:0]        op_a,
  input  logic [WIDTH-1:0]        op_b,
  input  logic [REG_ADDR_LEN-1:0] dest_in,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        result,
  output logic [REG_ADDR_LEN-1:0] dest_out,
  output logic                    div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] C_MUL = 3'b000, C_MULH = 3'b001, C_MULHU = 3'b010;
  localparam logic [2:0] C_DIV = 3'b100, C_DIVU = 3'b101, C_REM = 3'b110, C_REMU = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [WIDTH-1:0]        hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic                    neg_q, neg_d;
  logic [REG_ADDR_LEN-1:0] tag_q, tag_d, dest_out_q, dest_out_d;
  logic [WIDTH-1:0]        result_q, result_d;
  logic                    dbz_q, dbz_d;

  logic             accept, in_div, in_dbz, in_signed, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_sum, rem_sh;
  logic             ge;
  logic [WIDTH-1:0] step_hi, step_lo, mulh_neg, fin;

  always_comb begin
    accept    = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
    in_div    = cmd[2];
    in_dbz    = in_div && (op_b == '0);
    in_signed = (cmd == C_MULH) || (cmd == C_DIV) || (cmd == C_REM);
    sa        = in_signed && op_a[WIDTH-1];
    sb        = in_signed && op_b[WIDTH-1];
    mag_a     = sa ? -op_a : op_a;
    mag_b     = sb ? -op_b : op_b;
  end

  // hi:lo is the product (mul) or remainder:quotient-in-progress (div)
  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    ge      = rem_sh >= {1'b0, mcand_q};
    if (cmd_q[2]) begin
      step_hi = ge ? (rem_sh[WIDTH-1:0] - mcand_q) : rem_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      step_hi = add_sum[WIDTH:1];
      step_lo = {add_sum[0], lo_q[WIDTH-1:1]};
    end
    // high word of the negated 2*WIDTH product: borrow only when the low word is zero
    mulh_neg = ~step_hi + {{(WIDTH-1){1'b0}}, (step_lo == '0)};
    case (cmd_q)
      C_MUL:         fin = step_lo;
      C_MULH:        fin = neg_q ? mulh_neg : step_hi;
      C_MULHU:       fin = step_hi;
      C_DIV, C_DIVU: fin = neg_q ? -step_lo : step_lo;
      C_REM, C_REMU: fin = neg_q ? -step_hi : step_hi;
      default:       fin = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mcand_q    <= '0;
      neg_q      <= 1'b0;
      tag_q      <= '0;
      result_q   <= '0;
      dest_out_q <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mcand_q    <= mcand_d;
      neg_q      <= neg_d;
      tag_q      <= tag_d;
      result_q   <= result_d;
      dest_out_q <= dest_out_d;
      dbz_q      <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE, S_DONE: state_d = start ? (in_dbz ? S_DONE : S_RUN) : S_IDLE;
        S_RUN:          if (cnt_q == '0) state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mcand_d    = mcand_q;
    neg_d      = neg_q;
    tag_d      = tag_q;
    result_d   = result_q;
    dest_out_d = dest_out_q;
    dbz_d      = dbz_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept) begin
      cmd_d   = cmd;
      tag_d   = dest_in;
      cnt_d   = CW'(WIDTH-1);
      hi_d    = '0;
      lo_d    = in_div ? mag_a : mag_b;
      mcand_d = in_div ? mag_b : mag_a;
      neg_d   = (cmd == C_REM) ? sa : (sa ^ sb);
      if (in_dbz) begin
        cnt_d      = '0;
        result_d   = cmd[1] ? op_a : '1;
        dest_out_d = dest_in;
        dbz_d      = 1'b1;
      end
    end else if (state_q == S_RUN) begin
      hi_d = step_hi;
      lo_d = step_lo;
      if (cnt_q == '0) begin
        result_d   = fin;
        dest_out_d = tag_q;
        dbz_d      = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    busy        = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    result      = result_q;
    dest_out    = dest_out_q;
    div_by_zero = dbz_q;
  end
endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Bench for iter_muldiv_unit: directed cases plus random ops against a plain-arithmetic model.
module tb_iter_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush, busy, done, div_by_zero;
  logic [2:0]  cmd;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  dest_in, dest_out;
  int total = 0, bad = 0;

  iter_muldiv_unit #(.WIDTH(32), .REG_ADDR_LEN(5)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .op_a(op_a), .op_b(op_b),
    .dest_in(dest_in), .flush(flush), .busy(busy), .done(done), .result(result),
    .dest_out(dest_out), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // returns {div_by_zero, result}
  function automatic logic [32:0] ref_model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (c[2] && b == 32'd0) return {1'b1, (c[1] ? a : 32'hFFFF_FFFF)};
    case (c)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = longint'((64'(ua) * 64'(ub)) >> 32);
      3'd4: r = sa / sb;
      3'd5: r = ua / ub;
      3'd6: r = sa % sb;
      3'd7: r = ua % ub;
      default: r = 0;
    endcase
    return {1'b0, r[31:0]};
  endfunction

  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    logic [32:0] e;
    int lat, nbusy;
    e = ref_model(c, a, b);
    @(negedge clk);
    start = 1'b1; cmd = c; op_a = a; op_b = b; dest_in = d;
    lat = 0; nbusy = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) nbusy++;
    end while (!done && lat < 100);
    chk($sformatf("lat c%0d", c), 64'(lat), e[32] ? 64'd1 : 64'd33);
    chk($sformatf("busy c%0d", c), 64'(nbusy), e[32] ? 64'd0 : 64'd32);
    chk($sformatf("res c%0d %h/%h", c, a, b), 64'(result), 64'(e[31:0]));
    chk("dbz", 64'(div_by_zero), 64'(e[32]));
    chk("dest", 64'(dest_out), 64'(d));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prev_res;
    logic [4:0]  prev_dest;
    int ndone, d1, d2;
    logic [31:0] r1, r2;
    rst = 1'b1; start = 1'b0; flush = 1'b0; cmd = '0; op_a = '0; op_b = '0; dest_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 64'(busy), 0);
    chk("rst done", 64'(done), 0);
    chk("rst result", 64'(result), 0);
    chk("rst dest", 64'(dest_out), 0);
    chk("rst dbz", 64'(div_by_zero), 0);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'd6, 5'd9);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd1);
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 5'd2);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(3'd5, 32'd100, 32'd7, 5'd5);
    run_op(3'd7, 32'd100, 32'd7, 5'd6);
    run_op(3'd5, 32'd5, 32'd0, 5'd7);
    run_op(3'd6, 32'd5, 32'd0, 5'd8);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(3'd3, 32'd12, 32'd34, 5'd12);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd13);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom));

    // flush in cycle 10 of a MUL, with a competing start in the same cycle
    prev_res = result; prev_dest = dest_out;
    @(negedge clk);
    start = 1'b1; cmd = 3'd0; op_a = 32'd123; op_b = 32'd456; dest_in = 5'd17;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1; start = 1'b1; cmd = 3'd5; op_a = 32'd9; op_b = 32'd0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush busy", 64'(busy), 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("flush no done", 64'(ndone), 0);
    chk("flush result", 64'(result), 64'(prev_res));
    chk("flush dest", 64'(dest_out), 64'(prev_dest));

    // start held across two ops; operand change during RUN must be ignored
    start = 1'b1; cmd = 3'd0; op_a = 32'd3; op_b = 32'd4; dest_in = 5'd20;
    @(negedge clk);
    cmd = 3'd5; op_a = 32'd9; op_b = 32'd2; dest_in = 5'd21;
    d1 = 0; d2 = 0; r1 = '0; r2 = '0; ndone = 0;
    for (int cyc = 1; cyc <= 75; cyc++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin d1 = cyc; r1 = result; end
        else if (ndone == 2) begin d2 = cyc; r2 = result; end
      end
      if (cyc == 34) start = 1'b0;
      @(negedge clk);
    end
    chk("b2b done1 cyc", 64'(d1), 33);
    chk("b2b res1", 64'(r1), 12);
    chk("b2b done2 cyc", 64'(d2), 66);
    chk("b2b res2", 64'(r2), 4);
    chk("b2b ndone", 64'(ndone), 2);

    // reset in the middle of RUN
    start = 1'b1; cmd = 3'd0; op_a = 32'd5; op_b = 32'd5; dest_in = 5'd30;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst busy", 64'(busy), 0);
    chk("mid rst done", 64'(done), 0);
    chk("mid rst result", 64'(result), 0);
    chk("mid rst dest", 64'(dest_out), 0);
    chk("mid rst dbz", 64'(div_by_zero), 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid rst no done", 64'(ndone), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
